// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives 8N1 bytes on rx, packs them little-endian into
// WORD_BYTES-wide words and writes them to consecutive byte addresses.
// The load ends after DEPTH words, or after an idle timeout once data has
// arrived. Optional end-of-load XOR checksum: define UART_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned DEPTH        = 16384,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned TIMEOUT_BITS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_err,
  output logic                    chk_err
);

  localparam int unsigned DIV     = CLK_FREQ / BAUD;
  localparam int unsigned HALF    = DIV / 2;
  localparam int unsigned TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int unsigned W       = 8 * WORD_BYTES;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] LD_RUN  = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [1:0] LD_CHK  = 2'd1;
`endif
  localparam logic [1:0] LD_DONE = 2'd2;

  logic              rx_s1, rx_s2, rx_d;
  logic [1:0]        rx_st;
  logic [31:0]       cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [1:0]        ld_st;
  logic [W-1:0]      word_acc, word_next;
  logic [3:0]        byte_cnt;
  logic [31:0]       wcnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              got_byte;
  logic [31:0]       tmr;
  logic              start_ok, byte_ok, last_byte, last_word, timeout_hit;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        xsum;
`else
  assign chk_err = 1'b0;
`endif

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_ok  = (rx_st == RX_START) && (cnt == 32'(HALF - 1)) && !rx_s2;
  assign byte_ok   = (rx_st == RX_STOP) && (cnt == 32'(DIV - 1)) && rx_s2;
  assign last_byte = (byte_cnt == 4'(WORD_BYTES - 1));
  assign last_word = (wcnt == 32'(DEPTH - 1));
  assign timeout_hit = (TIMEOUT_BITS != 0) && (ld_st == LD_RUN) && got_byte &&
                       (rx_st == RX_IDLE) && (tmr == 32'(TO_CLKS - 1));

  // Insert the incoming byte into its lane of the word being assembled.
  always_comb begin
    word_next = word_acc;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      if (byte_cnt == 4'(k)) word_next[8*k +: 8] = shreg;
    end
  end

  // Serial receiver: start-bit validation at half period, 8 data bits, stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s2) rx_st <= RX_START;
        end
        RX_START: begin
          if (cnt == 32'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 32'd1;
        end
        RX_DATA: begin
          if (cnt == 32'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else cnt <= cnt + 32'd1;
        end
        default: begin
          if (cnt == 32'(DIV - 1)) begin
            cnt   <= '0;
            rx_st <= RX_IDLE;
            if (!rx_s2) frame_err <= 1'b1;
          end else cnt <= cnt + 32'd1;
        end
      endcase
    end
  end

  // Load control: word assembly, write strobes, idle timeout and termination.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_st    <= LD_RUN;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_acc <= '0;
      byte_cnt <= '0;
      wcnt     <= '0;
      addr_cnt <= ADDR_W'(BASE_ADDR);
      got_byte <= 1'b0;
      tmr      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      xsum     <= '0;
      chk_err  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start_ok && ld_st != LD_DONE) busy <= 1'b1;
      // done/busy follow the state one cycle late so done trails the last strobe.
      if (ld_st == LD_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (rx_st == RX_IDLE && ld_st == LD_RUN && got_byte) tmr <= tmr + 32'd1;
      else tmr <= '0;

      case (ld_st)
        LD_RUN: begin
          if (byte_ok) begin
            got_byte <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            xsum <= xsum ^ shreg;
`endif
            if (last_byte) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt;
              wr_data  <= word_next;
              word_acc <= '0;
              byte_cnt <= '0;
              wcnt     <= wcnt + 32'd1;
              addr_cnt <= addr_cnt + ADDR_W'(WORD_BYTES);
`ifdef UART_LOADER_CHECKSUM_EN
              if (last_word) ld_st <= LD_CHK;
`else
              if (last_word) ld_st <= LD_DONE;
`endif
            end else begin
              word_acc <= word_next;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (timeout_hit) begin
            // Unfilled upper lanes of word_acc are still zero.
            if (byte_cnt != 4'd0) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt;
              wr_data  <= word_acc;
              word_acc <= '0;
              byte_cnt <= '0;
            end
            ld_st <= LD_DONE;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        LD_CHK: begin
          if (byte_ok) begin
            chk_err <= (shreg != xsum);
            ld_st   <= LD_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: DIV=10, 4-byte words, DEPTH=2,
// base 0x100, idle timeout of 20 bit periods.
module tb_uart_mem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, frame_err, chk_err;

  int total = 0;
  int bad   = 0;

  int          w_n = 0;
  logic [31:0] w_addr [16];
  logic [31:0] w_data [16];
  logic        w_done [16];
  int          run = 0;
  int          max_run = 0;
  int          base;

  uart_mem_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .WORD_BYTES(4), .DEPTH(2),
    .ADDR_W(32), .BASE_ADDR('h100), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .frame_err(frame_err),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and the longest run of consecutive strobe cycles.
  always @(negedge clk) begin
    if (wr_en) begin
      if (w_n < 16) begin
        w_addr[w_n] = wr_addr;
        w_data[w_n] = wr_data;
        w_done[w_n] = done;
      end
      w_n = w_n + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(10);
    end
    rx = stop;
    tick(10);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    rx  = 1'b1;
    rst = 1'b1;
    tick(3);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_chk_err", 64'(chk_err), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    rst = 1'b0;

    // 1: two full words, then done; extra bytes ignored
    base = w_n;
    send(8'h78, 1'b1);
    check("t1_busy_mid", 64'(busy), 64'd1);
    send(8'h56, 1'b1);
    send(8'h34, 1'b1);
    send(8'h12, 1'b1);
    check("t1_w0_count", 64'(w_n - base), 64'd1);
    check("t1_w0_done_low", 64'(done), 64'd0);
    send(8'hEF, 1'b1);
    send(8'hBE, 1'b1);
    send(8'hAD, 1'b1);
    send(8'hDE, 1'b1);
    tick(5);
    check("t1_count", 64'(w_n - base), 64'd2);
    check("t1_addr0", 64'(w_addr[base]), 64'h100);
    check("t1_data0", 64'(w_data[base]), 64'h12345678);
    check("t1_addr1", 64'(w_addr[base+1]), 64'h104);
    check("t1_data1", 64'(w_data[base+1]), 64'hDEADBEEF);
    check("t1_done_after_strobe", 64'(w_done[base+1]), 64'd0);
    check("t1_strobe_width", 64'(max_run), 64'd1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_addr_hold", 64'(wr_addr), 64'h104);
    check("t1_data_hold", 64'(wr_data), 64'hDEADBEEF);
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    send(8'h77, 1'b1);
    send(8'h88, 1'b1);
    tick(5);
    check("t1_ignored", 64'(w_n - base), 64'd2);
    check("t1_done_sticky", 64'(done), 64'd1);

    // 2: short low glitch on idle line
    do_reset();
    base = w_n;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("t2_no_write", 64'(w_n - base), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_frame_err", 64'(frame_err), 64'd0);

    // 3: framing error byte is dropped
    do_reset();
    base = w_n;
    send(8'hAA, 1'b0);
    tick(10);
    check("t3_frame_err", 64'(frame_err), 64'd1);
    check("t3_no_write", 64'(w_n - base), 64'd0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    tick(5);
    check("t3_count", 64'(w_n - base), 64'd1);
    check("t3_addr", 64'(w_addr[base]), 64'h100);
    check("t3_data", 64'(w_data[base]), 64'h04030201);
    check("t3_done", 64'(done), 64'd0);
    check("t3_frame_sticky", 64'(frame_err), 64'd1);

    // 4: idle timeout flushes a zero-padded partial word
    do_reset();
    base = w_n;
    send(8'hAB, 1'b1);
    send(8'hCD, 1'b1);
    tick(150);
    check("t4_early_no_write", 64'(w_n - base), 64'd0);
    check("t4_early_done", 64'(done), 64'd0);
    tick(100);
    check("t4_count", 64'(w_n - base), 64'd1);
    check("t4_addr", 64'(w_addr[base]), 64'h100);
    check("t4_data", 64'(w_data[base]), 64'h0000CDAB);
    check("t4_done", 64'(done), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: reset mid-word discards partial data
    do_reset();
    base = w_n;
    send(8'h99, 1'b1);
    send(8'h88, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_busy_after_rst", 64'(busy), 64'd0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    tick(5);
    check("t5_count", 64'(w_n - base), 64'd1);
    check("t5_addr", 64'(w_addr[base]), 64'h100);
    check("t5_data", 64'(w_data[base]), 64'h44332211);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
